// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//  - state_t : controller state encoding
//  - clog2   : counter width helper usable in constant expressions
package mult_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ADD   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Smallest r with 2**r >= n.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the shift-add multiplier: sequences CHECK/ADD/SHIFT per
// multiplier bit, counts iterations and the DONE hold time.
// Ports:
//  i_clk, i_rst       clock, async active-high reset
//  i_init             start request (honoured in IDLE and DONE only)
//  i_b_lsb            current multiplier LSB
//  i_b_next_zero      multiplier is zero after the pending shift
//  o_load_c           accept operands this cycle (combinational strobe)
//  o_add_c            accumulate this cycle (combinational strobe)
//  o_sh_c             shift operands this cycle (combinational strobe)
//  o_fin_c            load product this cycle (combinational strobe)
//  o_busy, o_done     registered status
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DONE_HOLD = 31
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_init,
  input  logic i_b_lsb,
  input  logic i_b_next_zero,
  output logic o_load_c,
  output logic o_add_c,
  output logic o_sh_c,
  output logic o_fin_c,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned IW = clog2(WIDTH);
  localparam int unsigned HW = clog2(DONE_HOLD + 1);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_iter;
  logic [HW-1:0]   r_hold;
  logic            r_busy;
  logic            r_done;
  logic            w_iter_last;
  logic            w_hold_last;

  assign w_iter_last = (r_iter == IW'(WIDTH - 1));
  assign w_hold_last = (r_hold == HW'(DONE_HOLD - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and datapath strobes
  always_comb begin
    w_next   = r_state;
    o_load_c = 1'b0;
    o_add_c  = 1'b0;
    o_sh_c   = 1'b0;
    o_fin_c  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_init) begin
          o_load_c = 1'b1;
          w_next   = ST_CHECK;
        end
      end
      ST_CHECK: w_next = i_b_lsb ? ST_ADD : ST_SHIFT;
      ST_ADD: begin
        o_add_c = 1'b1;
        w_next  = ST_SHIFT;
      end
      ST_SHIFT: begin
        o_sh_c = 1'b1;
        // Stop at the highest set multiplier bit, or after the last bit.
        if (i_b_next_zero || w_iter_last) begin
          o_fin_c = 1'b1;
          w_next  = ST_DONE;
        end else begin
          w_next  = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (i_init) begin
          o_load_c = 1'b1;
          w_next   = ST_CHECK;
        end else if (w_hold_last) begin
          w_next   = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Iteration and hold counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iter <= '0;
      r_hold <= '0;
    end else if (o_load_c) begin
      r_iter <= '0;
      r_hold <= '0;
    end else begin
      if (o_sh_c)              r_iter <= r_iter + IW'(1);
      if (r_state == ST_DONE)  r_hold <= r_hold + HW'(1);
    end
  end

  // Status flags registered from the next state so they align with the state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == ST_CHECK) || (w_next == ST_ADD) || (w_next == ST_SHIFT);
      r_done <= (w_next == ST_DONE);
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/mult_seq_param.sv
// Parametrised sequential shift-add multiplier with optional signed mode,
// early termination at the highest multiplier bit and busy/done handshake.
// Ports:
//  i_clk, i_rst     clock, async active-high reset
//  i_init           start request (IDLE or DONE only)
//  i_signed_mode    operands are two's complement (when SIGNED_EN=1)
//  i_a, i_b         multiplicand / multiplier, latched on accept
//  o_busy           high while computing
//  o_done           high while result is being presented
//  o_product        2*WIDTH-bit result, held until the next completion
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SIGNED_EN = 1,
  parameter int unsigned DONE_HOLD = 31
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_init,
  input  logic               i_signed_mode,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic             r_sgn;
  logic [PW-1:0]    r_product;

  logic             w_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_load;
  logic             w_add;
  logic             w_sh;
  logic             w_fin;
  logic             w_b_next_zero;

  // Magnitudes; the most negative value maps to 2**(WIDTH-1), still unsigned-representable
  assign w_signed      = (SIGNED_EN != 0) && i_signed_mode;
  assign w_a_mag       = (w_signed && i_a[WIDTH-1]) ? (WIDTH'(0) - i_a) : i_a;
  assign w_b_mag       = (w_signed && i_b[WIDTH-1]) ? (WIDTH'(0) - i_b) : i_b;
  assign w_b_next_zero = (r_b[WIDTH-1:1] == '0);

  mult_seq_ctrl #(
    .WIDTH     (WIDTH),
    .DONE_HOLD (DONE_HOLD)
  ) u_ctrl (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_init        (i_init),
    .i_b_lsb       (r_b[0]),
    .i_b_next_zero (w_b_next_zero),
    .o_load_c      (w_load),
    .o_add_c       (w_add),
    .o_sh_c        (w_sh),
    .o_fin_c       (w_fin),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  // Operand, accumulator and product registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_sgn     <= 1'b0;
      r_product <= '0;
    end else begin
      if (w_load) begin
        r_a   <= PW'(w_a_mag);
        r_b   <= w_b_mag;
        r_acc <= '0;
        r_sgn <= w_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      end else if (w_add) begin
        r_acc <= r_acc + r_a;
      end else if (w_sh) begin
        r_a <= r_a << 1;
        r_b <= r_b >> 1;
      end
      // Accumulator is already final when the last SHIFT is reached
      if (w_fin) r_product <= r_sgn ? (PW'(0) - r_acc) : r_acc;
    end
  end

  assign o_product = r_product;

endmodule

// File: tb/tb_mult_seq_param.sv
module tb_mult_seq_param;

  logic        clk;
  logic        rst;
  logic        init;
  logic        sm;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        busy2;
  logic        done2;
  logic [31:0] product2;

  int total = 0;
  int bad   = 0;

  mult_seq_param #(.WIDTH(16), .SIGNED_EN(1), .DONE_HOLD(31)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_signed_mode(sm),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done), .o_product(product)
  );

  mult_seq_param #(.WIDTH(16), .SIGNED_EN(0), .DONE_HOLD(31)) u_dut_u (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_signed_mode(sm),
    .i_a(a), .i_b(b), .o_busy(busy2), .o_done(done2), .o_product(product2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [31:0] prod;
    int          edges;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Starts one operation (caller is at posedge+1 in IDLE or DONE) and waits for done.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vsm,
                        input bit scramble,
                        output int edges, output int busy_cycles,
                        output logic [31:0] p_first, output bit early_change,
                        output logic [31:0] p_final);
    a = va; b = vb; sm = vsm; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    edges = 1;
    busy_cycles = 0;
    p_first = product;
    early_change = 1'b0;
    while (!done && edges < 200) begin
      if (busy) busy_cycles++;
      if (scramble) begin
        a  = 16'($urandom);
        b  = 16'($urandom);
        sm = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
      if (!done && product !== p_first) early_change = 1'b1;
    end
    if (!done) check("done_timeout", 64'(done), 64'(1));
    p_final = product;
  endtask

  function automatic int model_edges(input logic [15:0] vb, input logic vsm);
    logic [15:0] mag;
    int last;
    int n;
    mag = (vsm && vb[15]) ? (16'(0) - vb) : vb;
    last = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) last = i;
    n = 1;
    for (int i = 0; i <= last; i++) n += 2 + int'(mag[i]);
    return n;
  endfunction

  function automatic logic [31:0] model_prod(input logic [15:0] va, input logic [15:0] vb,
                                             input logic vsm);
    longint p;
    if (vsm) p = longint'($signed(va)) * longint'($signed(vb));
    else     p = longint'({48'd0, va}) * longint'({48'd0, vb});
    return p[31:0];
  endfunction

  vec_t vecs[12];

  initial begin
    int          edges;
    int          bcyc;
    logic [31:0] pf;
    logic [31:0] pfin;
    bit          early;
    int          dcnt;
    int          pulses;
    int          consec;
    logic        prev;

    vecs[0]  = '{16'd3,      16'd5,      1'b0, 32'h0000000F, 9};
    vecs[1]  = '{16'hFFFD,   16'd5,      1'b1, 32'hFFFFFFF1, 9};
    vecs[2]  = '{16'h8000,   16'h8000,   1'b1, 32'h40000000, 34};
    vecs[3]  = '{16'h1234,   16'h0000,   1'b0, 32'h00000000, 3};
    vecs[4]  = '{16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFE0001, 49};
    vecs[5]  = '{16'h0000,   16'hFFFF,   1'b0, 32'h00000000, 49};
    vecs[6]  = '{16'd7,      16'hFFFF,   1'b1, 32'hFFFFFFF9, 4};
    vecs[7]  = '{16'hFFFF,   16'hFFFF,   1'b1, 32'h00000001, 4};
    vecs[8]  = '{16'd100,    16'hFFF6,   1'b1, 32'hFFFFFC18, 11};
    vecs[9]  = '{16'h1234,   16'h0100,   1'b0, 32'h00123400, 20};
    vecs[10] = '{16'h8000,   16'h0001,   1'b1, 32'hFFFF8000, 4};
    vecs[11] = '{16'h0000,   16'hFFFE,   1'b1, 32'h00000000, 6};

    rst = 1'b1; init = 1'b0; sm = 1'b0; a = '0; b = '0;
    #1;
    check("reset_busy",    64'(busy),    64'(0));
    check("reset_done",    64'(done),    64'(0));
    check("reset_product", 64'(product), 64'(0));
    check("reset_product_u", 64'(product2), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // SIGNED_EN=0 instance ignores signed_mode; both instances start together
    run_op(16'hFFFF, 16'd2, 1'b1, 1'b0, edges, bcyc, pf, early, pfin);
    check("sen1_prod",   64'(pfin),     64'(32'hFFFFFFFE));
    check("sen1_edges",  64'(edges),    64'(6));
    check("sen0_done",   64'(done2),    64'(1));
    check("sen0_prod",   64'(product2), 64'(32'h0001FFFE));

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0, edges, bcyc, pf, early, pfin);
      check($sformatf("vec%0d_prod", i),  64'(pfin),  64'(vecs[i].prod));
      check($sformatf("vec%0d_edges", i), 64'(edges), 64'(vecs[i].edges));
      check($sformatf("vec%0d_busy", i),  64'(bcyc),  64'(vecs[i].edges - 1));
    end

    // Done hold time then auto-return to IDLE
    run_op(16'd3, 16'd5, 1'b0, 1'b0, edges, bcyc, pf, early, pfin);
    dcnt = 1;
    while (done && dcnt < 100) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("hold_cycles",   64'(dcnt),    64'(31));
    check("idle_busy",     64'(busy),    64'(0));
    check("idle_product",  64'(product), 64'(32'h0000000F));

    // Restart from DONE cycle 5; old product visible until the new result loads
    run_op(16'd3, 16'd5, 1'b0, 1'b0, edges, bcyc, pf, early, pfin);
    repeat (4) begin @(posedge clk); #1; end
    check("restart_in_done", 64'(done), 64'(1));
    run_op(16'd6, 16'd7, 1'b0, 1'b0, edges, bcyc, pf, early, pfin);
    check("restart_old_prod", 64'(pf),    64'(32'h0000000F));
    check("restart_no_early", 64'(early), 64'(0));
    check("restart_prod",     64'(pfin),  64'(42));
    check("restart_edges",    64'(edges), 64'(10));

    // Operand changes after accept are ignored
    run_op(16'd3, 16'd5, 1'b0, 1'b1, edges, bcyc, pf, early, pfin);
    check("scramble_prod",  64'(pfin),  64'(32'h0000000F));
    check("scramble_edges", 64'(edges), 64'(9));

    // init held high: one done pulse per 9-edge pass
    a = 16'd3; b = 16'd5; sm = 1'b0; init = 1'b1;
    pulses = 0; consec = 0; prev = 1'b0;
    repeat (36) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (prev) consec++;
      end
      prev = done;
    end
    init = 1'b0;
    check("held_pulses",  64'(pulses),  64'(4));
    check("held_consec",  64'(consec),  64'(0));
    check("held_prod",    64'(product), 64'(32'h0000000F));

    // Asynchronous reset in the middle of an ADD
    a = 16'hFFFF; b = 16'hFFFF; sm = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_busy",    64'(busy),    64'(0));
    check("arst_done",    64'(done),    64'(0));
    check("arst_product", 64'(product), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(16'd3, 16'd5, 1'b0, 1'b0, edges, bcyc, pf, early, pfin);
    check("post_rst_prod",  64'(pfin),  64'(32'h0000000F));
    check("post_rst_edges", 64'(edges), 64'(9));

    // Random signed/unsigned sweep against a reference model
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rsm;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rsm = 1'($urandom);
      run_op(ra, rb, rsm, 1'b0, edges, bcyc, pf, early, pfin);
      check($sformatf("rnd%0d_prod a=%0h b=%0h s=%0d", k, ra, rb, rsm),
            64'(pfin), 64'(model_prod(ra, rb, rsm)));
      check($sformatf("rnd%0d_edges", k), 64'(edges), 64'(model_edges(rb, rsm)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
